fc_layer_seq: RTL and testbench
===============================

Name: fc_layer_seq

Overview:
Sequencer and MAC datapath for the fully-connected layer; the read-side master of the FC weight ROM (1-cycle registered read) and the feature buffer.
- On start, sweeps every weight address linearly and fetches the matching input feature.
- Accumulates signed products and emits one result per output neuron on a valid strobe.
- Sits between the last conv/pool feature buffer and the classification/argmax logic of the CNN.

Parameters:
FC_DATA_W, 8, signed width of weights and features
IN_NUM, 256, inputs per neuron (16*4*4 flattened features)
OUT_NUM, 32, output neurons
ADDR_W, $clog2(IN_NUM*OUT_NUM), weight ROM address width
FEAT_AW, $clog2(IN_NUM), feature buffer address width
ACC_W, 2*FC_DATA_W+$clog2(IN_NUM), signed accumulator/result width

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to run one full layer pass; ignored while busy
busy  out  1  high while a pass is in progress
done  out  1  one-cycle pulse coincident with the final out_valid
rom_raddr  out  ADDR_W  weight ROM read address
rom_dout  in  FC_DATA_W  weight ROM data, valid the cycle after its address
feat_raddr  out  FEAT_AW  feature buffer read address
feat_rdata  in  FC_DATA_W  feature data, valid the cycle after its address
out_valid  out  1  one-cycle strobe, out_data/out_idx valid
out_data  out  ACC_W  signed dot product for neuron out_idx
out_idx  out  $clog2(OUT_NUM)  neuron index of out_data

Behaviour:
- Reset: all outputs 0; state IDLE; counters and accumulator 0. Asserting reset mid-pass aborts immediately and discards partial sums; no out_valid/done is produced for the aborted pass.
- States:
  - IDLE: start=1 -> RUN next cycle.
  - RUN: lasts exactly IN_NUM*OUT_NUM cycles, one issue per cycle, no stalls. After the last issue -> DRAIN.
  - DRAIN: 2 cycles -> IDLE.
- busy = (state != IDLE).
- Issue stage, RUN cycle k (k=0..IN_NUM*OUT_NUM-1):
  - rom_raddr = k.
  - feat_raddr = k mod IN_NUM.
  - Tag first = (k mod IN_NUM == 0), last = (k mod IN_NUM == IN_NUM-1), idx = k / IN_NUM.
  - Tags are delayed 1 cycle to align with the read data.
  - Addresses are registered. Outside RUN they hold their last value; they are 0 after reset.
- MAC stage, cycle after issue:
  - prod = signed(rom_dout) * signed(feat_rdata), full 2*FC_DATA_W bits, sign-extended to ACC_W.
  - acc <= first ? prod : acc + prod.
  - No saturation or truncation; ACC_W cannot overflow for any input values.
- Output stage: when the MAC stage processes a last-tagged element:
  - Next cycle out_valid=1, out_data = final sum (same value registered into acc), out_idx = idx.
  - Latency: last issue of neuron n in cycle t -> out_valid in cycle t+2.
  - Outputs are issued in order 0..OUT_NUM-1.
- done pulses with the out_valid for idx OUT_NUM-1. That is the last DRAIN cycle, so busy falls the cycle after.
- start during RUN/DRAIN is ignored, not queued. start in the same cycle busy falls is honoured only if state==IDLE, i.e. not in that cycle.
- out_data and out_idx hold their values between strobes.

Decomposition:
- Package fc_pkg:
  - Constants FC_DATA_W, IN_NUM, OUT_NUM, ACC_W.
  - State enum {IDLE, RUN, DRAIN}.
  - Shared by the weight ROM instance and the argmax block.
- Sub-module fc_mac:
  - Signed multiplier plus accumulator with first/last/idx tag pipeline.
  - Produces acc, out_valid, out_data, out_idx.
  - Top keeps the FSM and address counters.

Test Plan (IN_NUM=4, OUT_NUM=2, ROM 1-cycle model; start high in cycle 0):
1. All weights 0x01, features 1,2,3,4 -> rom_raddr 0..7 in cycles 1..8; feat_raddr 0,1,2,3,0,1,2,3; out_valid cycle 6 (idx 0, data 10) and cycle 10 (idx 1, data 10, done=1); busy high cycles 1..10.
2. Weights 0x80, features 0x80 -> both outputs 65536. Weights 0x7F, features 0x80 -> both outputs -65024 (18-bit signed, no wrap).
3. Weights 0..7 (neuron 0: 0,1,2,3; neuron 1: 4,5,6,7), features 1,-1,1,-1 -> out0 = -2, out1 = -2; confirms first-tag clears acc between neurons.
4. start re-pulsed in cycles 3 and 9 -> ignored, exactly two out_valid; new start in cycle 11 -> identical pass, out_valid cycles 17 and 21.
5. rst_n low in cycle 5 of a pass -> all outputs 0 asynchronously, no out_valid/done; release then start -> full correct results as scenario 1.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared constants and state encoding for the fully-connected layer
// (sequencer, weight ROM instance and argmax block).
package fc_pkg;
    localparam int FC_DATA_W = 8;
    localparam int IN_NUM    = 256;
    localparam int OUT_NUM   = 32;
    localparam int ACC_W     = 2 * FC_DATA_W + $clog2(IN_NUM);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;
endpackage

// File: rtl/fc_mac.sv
// Signed multiply-accumulate stage with first/last/idx tag pipeline; emits one
// registered dot product per output neuron.
module fc_mac #(
    parameter int FC_DATA_W = 8,
    parameter int ACC_W     = 18,
    parameter int OUT_NUM   = 2,
    parameter int IDX_W     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    input  logic                 issue_first,
    input  logic                 issue_last,
    input  logic [IDX_W-1:0]     issue_idx,
    input  logic [FC_DATA_W-1:0] weight,
    input  logic [FC_DATA_W-1:0] feature,
    output logic                 out_valid,
    output logic [ACC_W-1:0]     out_data,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 done
);
    logic                       tag_valid;
    logic                       tag_first;
    logic                       tag_last;
    logic [IDX_W-1:0]           tag_idx;
    logic signed [ACC_W-1:0]    acc;
    logic signed [2*FC_DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    sum;

    // Full-width signed product; the size cast sign-extends into the accumulator width.
    assign prod     = $signed(weight) * $signed(feature);
    assign prod_ext = ACC_W'(prod);
    assign sum      = tag_first ? prod_ext : acc + prod_ext;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= 1'b0;
            tag_first <= 1'b0;
            tag_last  <= 1'b0;
            tag_idx   <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            done      <= 1'b0;
        end else begin
            tag_valid <= issue_valid;
            tag_first <= issue_first;
            tag_last  <= issue_last;
            tag_idx   <= issue_idx;
            if (tag_valid) begin
                acc <= sum;
            end
            out_valid <= tag_valid && tag_last;
            done      <= tag_valid && tag_last && (tag_idx == IDX_W'(OUT_NUM - 1));
            if (tag_valid && tag_last) begin
                out_data <= sum;
                out_idx  <= tag_idx;
            end
        end
    end
endmodule

// File: rtl/fc_layer_seq.sv
// FC layer sequencer: sweeps the weight ROM linearly, fetches matching
// features and feeds the MAC stage; one result strobe per output neuron.
module fc_layer_seq #(
    parameter int FC_DATA_W = fc_pkg::FC_DATA_W,
    parameter int IN_NUM    = fc_pkg::IN_NUM,
    parameter int OUT_NUM   = fc_pkg::OUT_NUM,
    localparam int ADDR_W   = $clog2(IN_NUM * OUT_NUM),
    localparam int FEAT_AW  = $clog2(IN_NUM),
    localparam int ACC_W    = 2 * FC_DATA_W + $clog2(IN_NUM),
    localparam int IDX_W    = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    rom_raddr,
    input  logic [FC_DATA_W-1:0] rom_dout,
    output logic [FEAT_AW-1:0]   feat_raddr,
    input  logic [FC_DATA_W-1:0] feat_rdata,
    output logic                 out_valid,
    output logic [ACC_W-1:0]     out_data,
    output logic [IDX_W-1:0]     out_idx
);
    import fc_pkg::*;

    localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(IN_NUM * OUT_NUM - 1);
    localparam logic [FEAT_AW-1:0] FEAT_LAST = FEAT_AW'(IN_NUM - 1);

    state_t           state;
    logic             drain_cnt;
    logic [IDX_W-1:0] neuron;

    assign busy = (state != IDLE);

    // Addresses are the issue counters themselves, so they hold after a pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            drain_cnt  <= 1'b0;
            rom_raddr  <= '0;
            feat_raddr <= '0;
            neuron     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        rom_raddr  <= '0;
                        feat_raddr <= '0;
                        neuron     <= '0;
                    end
                end
                RUN: begin
                    if (rom_raddr == ADDR_LAST) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end else begin
                        rom_raddr <= rom_raddr + ADDR_W'(1);
                        if (feat_raddr == FEAT_LAST) begin
                            feat_raddr <= '0;
                            neuron     <= neuron + IDX_W'(1);
                        end else begin
                            feat_raddr <= feat_raddr + FEAT_AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        state <= IDLE;
                    end
                    drain_cnt <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fc_mac #(
        .FC_DATA_W (FC_DATA_W),
        .ACC_W     (ACC_W),
        .OUT_NUM   (OUT_NUM),
        .IDX_W     (IDX_W)
    ) u_mac (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (state == RUN),
        .issue_first (feat_raddr == '0),
        .issue_last  (feat_raddr == FEAT_LAST),
        .issue_idx   (neuron),
        .weight      (rom_dout),
        .feature     (feat_rdata),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .done        (done)
    );
endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench for fc_layer_seq with IN_NUM=4, OUT_NUM=2 and 1-cycle ROM /
// feature buffer models; cycle 0 is the cycle in which start is high.
module tb_fc_layer_seq;
    localparam int FC_DATA_W = 8;
    localparam int IN_NUM    = 4;
    localparam int OUT_NUM   = 2;
    localparam int ADDR_W    = 3;
    localparam int FEAT_AW   = 2;
    localparam int ACC_W     = 18;
    localparam int IDX_W     = 1;
    localparam int MAXC      = 32;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 busy;
    logic                 done;
    logic [ADDR_W-1:0]    rom_raddr;
    logic [FC_DATA_W-1:0] rom_dout;
    logic [FEAT_AW-1:0]   feat_raddr;
    logic [FC_DATA_W-1:0] feat_rdata;
    logic                 out_valid;
    logic [ACC_W-1:0]     out_data;
    logic [IDX_W-1:0]     out_idx;

    logic [FC_DATA_W-1:0] rom_mem  [IN_NUM*OUT_NUM];
    logic [FC_DATA_W-1:0] feat_mem [IN_NUM];

    int errors = 0;
    int checks = 0;

    int log_valid [MAXC];
    int log_data  [MAXC];
    int log_idx   [MAXC];
    int log_done  [MAXC];
    int log_busy  [MAXC];
    int log_raddr [MAXC];
    int log_faddr [MAXC];

    typedef struct {
        string                      name;
        logic [7:0][FC_DATA_W-1:0]  w;
        logic [3:0][FC_DATA_W-1:0]  f;
        int                         e0;
        int                         e1;
    } vec_t;

    vec_t vecs [4];

    fc_layer_seq #(
        .FC_DATA_W (FC_DATA_W),
        .IN_NUM    (IN_NUM),
        .OUT_NUM   (OUT_NUM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .rom_raddr  (rom_raddr),
        .rom_dout   (rom_dout),
        .feat_raddr (feat_raddr),
        .feat_rdata (feat_rdata),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_idx    (out_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_dout   <= rom_mem[rom_raddr];
        feat_rdata <= feat_mem[feat_raddr];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_data"}, int'(out_data), 0);
        check({tag, "_out_idx"}, int'(out_idx), 0);
        check({tag, "_rom_raddr"}, int'(rom_raddr), 0);
        check({tag, "_feat_raddr"}, int'(feat_raddr), 0);
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < IN_NUM * OUT_NUM; i++) rom_mem[i] = v.w[i];
        for (int i = 0; i < IN_NUM; i++) feat_mem[i] = v.f[i];
    endtask

    // Runs ncyc cycles; smask[c] drives start in cycle c, rst_n is low in cycles rlo..rhi.
    task automatic capture(input int ncyc, input logic [31:0] smask, input int rlo, input int rhi);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            start = smask[c];
            rst_n = (c >= rlo && c <= rhi) ? 1'b0 : 1'b1;
            if (c == rlo) begin
                #1;
                check_zero_outputs("abort_async");
            end
            @(negedge clk);
            log_valid[c] = int'(out_valid);
            log_data[c]  = $signed(out_data);
            log_idx[c]   = int'(out_idx);
            log_done[c]  = int'(done);
            log_busy[c]  = int'(busy);
            log_raddr[c] = int'(rom_raddr);
            log_faddr[c] = int'(feat_raddr);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    // Checks one pass whose start cycle is s against the expected neuron sums.
    task automatic check_pass(input string name, input int s, input int e0, input int e1);
        int nv;
        int nd;
        int bad_busy;
        nv = 0;
        nd = 0;
        bad_busy = 0;
        for (int c = s; c <= s + 11; c++) begin
            nv += log_valid[c];
            nd += log_done[c];
            if (log_busy[c] != ((c >= s + 1 && c <= s + 10) ? 1 : 0)) bad_busy++;
        end
        check({name, "_valid_count"}, nv, 2);
        check({name, "_done_count"}, nd, 1);
        check({name, "_busy_window"}, bad_busy, 0);
        check({name, "_valid_n0"}, log_valid[s + 6], 1);
        check({name, "_idx_n0"}, log_idx[s + 6], 0);
        check({name, "_data_n0"}, log_data[s + 6], e0);
        check({name, "_done_n0"}, log_done[s + 6], 0);
        check({name, "_valid_n1"}, log_valid[s + 10], 1);
        check({name, "_idx_n1"}, log_idx[s + 10], 1);
        check({name, "_data_n1"}, log_data[s + 10], e1);
        check({name, "_done_n1"}, log_done[s + 10], 1);
        check({name, "_data_hold"}, log_data[s + 11], e1);
    endtask

    initial begin
        int bad_ra;
        int bad_fa;
        int nv;
        int nd;

        vecs[0].name = "ones";
        vecs[0].w    = {8{8'h01}};
        vecs[0].f    = {8'd4, 8'd3, 8'd2, 8'd1};
        vecs[0].e0   = 10;
        vecs[0].e1   = 10;
        vecs[1].name = "min_min";
        vecs[1].w    = {8{8'h80}};
        vecs[1].f    = {4{8'h80}};
        vecs[1].e0   = 65536;
        vecs[1].e1   = 65536;
        vecs[2].name = "max_min";
        vecs[2].w    = {8{8'h7F}};
        vecs[2].f    = {4{8'h80}};
        vecs[2].e0   = -65024;
        vecs[2].e1   = -65024;
        vecs[3].name = "ramp_alt";
        vecs[3].w    = {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        vecs[3].f    = {8'hFF, 8'h01, 8'hFF, 8'h01};
        vecs[3].e0   = -2;
        vecs[3].e1   = -2;

        load(vecs[0]);
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 4; i++) begin
            load(vecs[i]);
            capture(14, 32'h1, -1, -1);
            check_pass(vecs[i].name, 0, vecs[i].e0, vecs[i].e1);
            if (i == 0) begin
                bad_ra = 0;
                bad_fa = 0;
                for (int c = 1; c <= 8; c++) begin
                    if (log_raddr[c] != c - 1) bad_ra++;
                    if (log_faddr[c] != (c - 1) % IN_NUM) bad_fa++;
                end
                check("ones_rom_raddr_sweep", bad_ra, 0);
                check("ones_feat_raddr_sweep", bad_fa, 0);
                check("ones_rom_raddr_hold", log_raddr[12], 7);
                check("ones_feat_raddr_hold", log_faddr[12], 3);
            end
        end

        // start re-pulsed mid-pass and in DRAIN is ignored; cycle 11 starts a fresh pass
        load(vecs[0]);
        capture(24, (32'h1 << 0) | (32'h1 << 3) | (32'h1 << 9) | (32'h1 << 11), -1, -1);
        check_pass("restart_p0", 0, 10, 10);
        check_pass("restart_p1", 11, 10, 10);
        nv = 0;
        for (int c = 0; c < 24; c++) nv += log_valid[c];
        check("restart_total_valid", nv, 4);

        // reset in cycle 5 aborts the pass with no result strobes
        load(vecs[3]);
        capture(14, 32'h1, 5, 7);
        nv = 0;
        nd = 0;
        for (int c = 0; c < 14; c++) begin
            nv += log_valid[c];
            nd += log_done[c];
        end
        check("abort_valid_count", nv, 0);
        check("abort_done_count", nd, 0);

        load(vecs[0]);
        capture(14, 32'h1, -1, -1);
        check_pass("after_abort", 0, 10, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
